// File: rtl/taxi_stats_gen.sv
// Statistics increment source: per-channel accumulators drained as AXI4-Stream stat records.
// Define TAXI_STATS_GEN_ZERO_SKIP_EN to skip channels with nothing to report during a scan.
module taxi_stats_gen #(
  parameter int unsigned CNT           = 8,
  parameter int unsigned INC_W         = 1,
  parameter int unsigned STAT_INC_W    = 16,
  parameter int unsigned ID_W          = 10,
  parameter int unsigned ID_BASE       = 0,
  parameter int unsigned UPDATE_PERIOD = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CNT*INC_W-1:0]  stat_inc_i,
  input  logic [CNT-1:0]        stat_valid_i,
  input  logic                  flush_req_i,
  output logic                  busy_o,
  output logic [STAT_INC_W-1:0] m_axis_stat_tdata_o,
  output logic [ID_W-1:0]       m_axis_stat_tid_o,
  output logic                  m_axis_stat_tuser_o,
  output logic                  m_axis_stat_tvalid_o,
  input  logic                  m_axis_stat_tready_i
);

  localparam int unsigned PtrW = (CNT > 1) ? $clog2(CNT) : 1;

  typedef enum logic [1:0] {StIdle, StScan, StEmit} state_e;

  state_e                state_q, state_d;
  logic [PtrW-1:0]       ptr_q, ptr_d;
  logic                  pend_q, pend_d;
  logic                  pend_clr;
  logic                  capture;
  logic                  emit_hit;
  logic                  wrap;
  logic                  any_msb;

  logic [STAT_INC_W-1:0] acc_q [CNT];
  logic [STAT_INC_W-1:0] acc_d [CNT];
  logic [STAT_INC_W:0]   inc_ext [CNT];
  logic [STAT_INC_W:0]   sum [CNT];
  logic [CNT-1:0]        sat_q, sat_d;

  logic [STAT_INC_W-1:0] tdata_q, tdata_d;
  logic [ID_W-1:0]       tid_q, tid_d;
  logic                  tuser_q, tuser_d;
  logic                  tvalid_q, tvalid_d;

  // Period counter; UPDATE_PERIOD of 0 leaves only flush and urgent triggers.
  if (UPDATE_PERIOD != 0) begin : g_period
    localparam int unsigned PerW = (UPDATE_PERIOD > 1) ? $clog2(UPDATE_PERIOD) : 1;
    logic [PerW-1:0] per_q;

    assign wrap = (per_q == PerW'(UPDATE_PERIOD - 1));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        per_q <= '0;
      end else begin
        per_q <= wrap ? '0 : per_q + PerW'(1);
      end
    end
  end else begin : g_no_period
    assign wrap = 1'b0;
  end

`ifdef TAXI_STATS_GEN_ZERO_SKIP_EN
  assign emit_hit = (acc_q[ptr_q] != '0) || sat_q[ptr_q];
`else
  assign emit_hit = 1'b1;
`endif

  // Accumulate with saturation; the captured channel restarts from this cycle's increment.
  always_comb begin
    any_msb = 1'b0;
    sat_d   = sat_q;
    for (int i = 0; i < CNT; i++) begin
      inc_ext[i] = stat_valid_i[i] ?
                   {{(STAT_INC_W + 1 - INC_W){1'b0}}, stat_inc_i[i*INC_W +: INC_W]} : '0;
      sum[i]     = {1'b0, acc_q[i]} + inc_ext[i];
      if (capture && (ptr_q == PtrW'(i))) begin
        acc_d[i] = inc_ext[i][STAT_INC_W-1:0];
        sat_d[i] = 1'b0;
      end else if (sum[i][STAT_INC_W]) begin
        acc_d[i] = '1;
        sat_d[i] = 1'b1;
      end else begin
        acc_d[i] = sum[i][STAT_INC_W-1:0];
      end
      any_msb = any_msb | acc_q[i][STAT_INC_W-1];
    end
  end

  assign pend_d = (pend_q & ~pend_clr) | wrap | flush_req_i | any_msb;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    pend_clr = 1'b0;
    capture  = 1'b0;
    tdata_d  = tdata_q;
    tid_d    = tid_q;
    tuser_d  = tuser_q;
    tvalid_d = tvalid_q;
    unique case (state_q)
      StIdle: begin
        if (pend_q) begin
          state_d  = StScan;
          ptr_d    = '0;
          pend_clr = 1'b1;
        end
      end
      StScan: begin
        if (emit_hit) begin
          capture  = 1'b1;
          tdata_d  = acc_q[ptr_q];
          tid_d    = ID_W'(ID_BASE) + ID_W'(ptr_q);
          tuser_d  = sat_q[ptr_q];
          tvalid_d = 1'b1;
          state_d  = StEmit;
        end else if (ptr_q == PtrW'(CNT - 1)) begin
          state_d = StIdle;
        end else begin
          ptr_d = ptr_q + PtrW'(1);
        end
      end
      StEmit: begin
        if (m_axis_stat_tready_i) begin
          tvalid_d = 1'b0;
          if (ptr_q == PtrW'(CNT - 1)) begin
            state_d = StIdle;
          end else begin
            ptr_d   = ptr_q + PtrW'(1);
            state_d = StScan;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      ptr_q    <= '0;
      pend_q   <= 1'b0;
      acc_q    <= '{default: '0};
      sat_q    <= '0;
      tdata_q  <= '0;
      tid_q    <= '0;
      tuser_q  <= 1'b0;
      tvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      pend_q   <= pend_d;
      acc_q    <= acc_d;
      sat_q    <= sat_d;
      tdata_q  <= tdata_d;
      tid_q    <= tid_d;
      tuser_q  <= tuser_d;
      tvalid_q <= tvalid_d;
    end
  end

  assign busy_o               = (state_q != StIdle);
  assign m_axis_stat_tdata_o  = tdata_q;
  assign m_axis_stat_tid_o    = tid_q;
  assign m_axis_stat_tuser_o  = tuser_q;
  assign m_axis_stat_tvalid_o = tvalid_q;

endmodule
